// File: rtl/iob_uart16550_stream_bridge.sv
// Wishbone master that configures an iob_uart16550 core, then polls LSR to move
// bytes between valid/ready streams and the UART FIFOs with sticky error capture.
module iob_uart16550_stream_bridge #(
    parameter int          ADDR_W   = 5,
    parameter logic [7:0]  LCR_CFG  = 8'h1B,
    parameter logic [7:0]  IER_CFG  = 8'h00,
    parameter int          RX_DEPTH = 4,
    parameter int          TX_BURST = 16
) (
    input  logic              clk,
    input  logic              wb_rst_i,
    output logic [ADDR_W-1:0] wb_adr_o,
    output logic [31:0]       wb_dat_o,
    input  logic [31:0]       wb_dat_i,
    output logic [3:0]        wb_sel_o,
    output logic              wb_we_o,
    output logic              wb_stb_o,
    output logic              wb_cyc_o,
    input  logic              wb_ack_i,
    input  logic [15:0]       div_i,
    input  logic              cfg_req_i,
    output logic              cfg_done_o,
    input  logic [7:0]        tx_data_i,
    input  logic              tx_valid_i,
    output logic              tx_ready_o,
    output logic [7:0]        rx_data_o,
    output logic              rx_valid_o,
    input  logic              rx_ready_i,
    output logic [2:0]        err_o,
    input  logic              err_clr_i
);

    localparam int PW = $clog2(RX_DEPTH);
    localparam int CW = PW + 1;
    localparam int BW = $clog2(TX_BURST + 1);

    typedef enum logic [2:0] {
        CFG_DLAB,
        CFG_DL1,
        CFG_DL2,
        CFG_LCR,
        CFG_IER,
        POLL_LSR,
        RD_RB,
        WR_THR
    } state_t;

    state_t            state;
    state_t            acc_state;
    logic [15:0]       div_q;
    logic [BW-1:0]     burst_cnt;
    logic              cfg_pend;

    logic [7:0]        mem [RX_DEPTH];
    logic [PW-1:0]     wptr;
    logic [PW-1:0]     rptr;
    logic [CW-1:0]     count;

    logic [ADDR_W-1:0] acc_adr;
    logic              acc_we;
    logic [7:0]        acc_byte;
    logic [7:0]        rd_byte;
    logic [2:0]        err_set;
    logic              ack_now;
    logic              push;
    logic              pop;
    logic              full;

    assign ack_now    = wb_cyc_o & wb_ack_i;
    assign rd_byte    = 8'(wb_dat_i >> {wb_adr_o[1:0], 3'b000});
    assign full       = (count == CW'(RX_DEPTH));
    assign push       = ack_now && (state == RD_RB);
    assign rx_valid_o = (count != '0);
    assign pop        = rx_valid_o && rx_ready_i;
    assign rx_data_o  = mem[rptr];
    assign tx_ready_o = ack_now && (state == WR_THR);
    assign err_set    = (ack_now && state == POLL_LSR) ? rd_byte[3:1] : 3'b000;

    // Access to launch from the idle cycle; a finished or empty burst falls back to an LSR poll.
    always_comb begin
        acc_state = state;
        acc_adr   = '0;
        acc_we    = 1'b0;
        acc_byte  = 8'h00;
        case (state)
            CFG_DLAB: begin acc_adr = ADDR_W'(3); acc_we = 1'b1; acc_byte = LCR_CFG | 8'h80; end
            CFG_DL1:  begin acc_adr = ADDR_W'(0); acc_we = 1'b1; acc_byte = div_q[7:0]; end
            CFG_DL2:  begin acc_adr = ADDR_W'(1); acc_we = 1'b1; acc_byte = div_q[15:8]; end
            CFG_LCR:  begin acc_adr = ADDR_W'(3); acc_we = 1'b1; acc_byte = LCR_CFG & 8'h7F; end
            CFG_IER:  begin acc_adr = ADDR_W'(1); acc_we = 1'b1; acc_byte = IER_CFG; end
            POLL_LSR: acc_adr = ADDR_W'(5);
            RD_RB:    acc_adr = ADDR_W'(0);
            WR_THR: begin
                if (tx_valid_i && burst_cnt < BW'(TX_BURST)) begin
                    acc_adr  = ADDR_W'(0);
                    acc_we   = 1'b1;
                    acc_byte = tx_data_i;
                end else begin
                    acc_adr   = ADDR_W'(5);
                    acc_state = POLL_LSR;
                end
            end
            default: acc_adr = ADDR_W'(5);
        endcase
    end

    always_ff @(posedge clk or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state      <= CFG_DLAB;
            wb_cyc_o   <= 1'b0;
            wb_stb_o   <= 1'b0;
            wb_we_o    <= 1'b0;
            wb_adr_o   <= '0;
            wb_dat_o   <= '0;
            wb_sel_o   <= '0;
            div_q      <= 16'd1;
            burst_cnt  <= '0;
            cfg_pend   <= 1'b0;
            cfg_done_o <= 1'b0;
        end else begin
            cfg_pend <= cfg_pend | cfg_req_i;
            if (!wb_cyc_o) begin
                if (!wb_ack_i) begin
                    wb_cyc_o <= 1'b1;
                    wb_stb_o <= 1'b1;
                    wb_we_o  <= acc_we;
                    wb_adr_o <= acc_adr;
                    wb_dat_o <= acc_we ? (32'(acc_byte) << {acc_adr[1:0], 3'b000}) : 32'h0;
                    wb_sel_o <= 4'b0001 << acc_adr[1:0];
                    state    <= acc_state;
                    if (state == CFG_DLAB)
                        div_q <= (div_i == 16'd0) ? 16'd1 : div_i;
                end
            end else if (wb_ack_i) begin
                wb_cyc_o <= 1'b0;
                wb_stb_o <= 1'b0;
                case (state)
                    CFG_DLAB: state <= CFG_DL1;
                    CFG_DL1:  state <= CFG_DL2;
                    CFG_DL2:  state <= CFG_LCR;
                    CFG_LCR:  state <= CFG_IER;
                    CFG_IER: begin
                        state      <= POLL_LSR;
                        cfg_done_o <= 1'b1;
                    end
                    POLL_LSR: begin
                        if (cfg_pend) begin
                            state      <= CFG_DLAB;
                            cfg_done_o <= 1'b0;
                            cfg_pend   <= cfg_req_i;
                        end else if (rd_byte[0] && !full) begin
                            state <= RD_RB;
                        end else if (rd_byte[5] && tx_valid_i) begin
                            state     <= WR_THR;
                            burst_cnt <= '0;
                        end
                    end
                    RD_RB:   state <= POLL_LSR;
                    WR_THR:  burst_cnt <= burst_cnt + 1'b1;
                    default: state <= POLL_LSR;
                endcase
            end
        end
    end

    // Sticky error flags: a clear loses to a new set in the same cycle.
    always_ff @(posedge clk or posedge wb_rst_i) begin
        if (wb_rst_i)
            err_o <= 3'b000;
        else
            err_o <= (err_clr_i ? 3'b000 : err_o) | err_set;
    end

    always_ff @(posedge clk or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            for (int i = 0; i < RX_DEPTH; i++)
                mem[i] <= 8'h00;
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                mem[wptr] <= rd_byte;
                wptr      <= wptr + 1'b1;
            end
            if (pop)
                rptr <= rptr + 1'b1;
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;
        end
    end

endmodule

// File: tb/tb_iob_uart16550_stream_bridge.sv
// Directed bench for the UART stream bridge against a behavioural UART register model
// with THR-to-RX loopback, forced LSR error bits and an ack stall control.
module tb_iob_uart16550_stream_bridge;

    logic        clk = 1'b0;
    logic        wb_rst_i = 1'b0;
    logic [4:0]  wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [31:0] wb_dat_i;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o, wb_stb_o, wb_cyc_o, wb_ack_i;
    logic [15:0] div_i = 16'd2;
    logic        cfg_req_i = 1'b0;
    logic        cfg_done_o;
    logic [7:0]  tx_data_i = 8'h00;
    logic        tx_valid_i = 1'b0;
    logic        tx_ready_o;
    logic [7:0]  rx_data_o;
    logic        rx_valid_o;
    logic        rx_ready_i = 1'b0;
    logic [2:0]  err_o;
    logic        err_clr_i = 1'b0;

    int errors = 0;
    int checks = 0;

    logic       stall = 1'b0, thre = 1'b1, loopback = 1'b0;
    logic       f_fe = 1'b0, f_pe = 1'b0, f_oe = 1'b0;
    logic [7:0] rx_mem [64];
    int         rx_rd = 0, rx_wr = 0;
    logic [7:0] mdl_lcr = 8'h00;
    logic [7:0] lsr, slv_byte, wr_byte;
    logic       inj_go = 1'b0;
    logic [7:0] inj_byte = 8'h00;

    logic [4:0]  log_adr  [4096];
    logic        log_we   [4096];
    logic [7:0]  log_byte [4096];
    logic [31:0] log_dat  [4096];
    logic [3:0]  log_sel  [4096];
    logic        log_done [4096];
    int          log_n = 0;
    int          thr_cnt = 0, consec = 0, max_consec = 0, rb_reads = 0;

    logic [7:0] rx_got [64];
    int         rx_n = 0;
    logic [7:0] tx_src [32];

    always #5 clk = ~clk;

    iob_uart16550_stream_bridge #(
        .ADDR_W(5), .LCR_CFG(8'h1B), .IER_CFG(8'h00), .RX_DEPTH(4), .TX_BURST(4)
    ) dut (
        .clk(clk), .wb_rst_i(wb_rst_i),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_sel_o(wb_sel_o),
        .wb_we_o(wb_we_o), .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o), .wb_ack_i(wb_ack_i),
        .div_i(div_i), .cfg_req_i(cfg_req_i), .cfg_done_o(cfg_done_o),
        .tx_data_i(tx_data_i), .tx_valid_i(tx_valid_i), .tx_ready_o(tx_ready_o),
        .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o), .rx_ready_i(rx_ready_i),
        .err_o(err_o), .err_clr_i(err_clr_i)
    );

    assign wb_ack_i = wb_cyc_o & wb_stb_o & ~stall;

    always_comb begin
        lsr      = {1'b0, thre, thre, 1'b0, f_fe, f_pe, f_oe, (rx_rd != rx_wr)};
        slv_byte = 8'h00;
        if (wb_adr_o == 5'd5)
            slv_byte = lsr;
        else if (wb_adr_o == 5'd0)
            slv_byte = rx_mem[rx_rd[5:0]];
        wb_dat_i = 32'(slv_byte) << {wb_adr_o[1:0], 3'b000};
        wr_byte  = 8'(wb_dat_o >> {wb_adr_o[1:0], 3'b000});
    end

    // UART register model and bus log; state seen by the DUT changes with <= only.
    always @(posedge clk) begin
        if (inj_go) begin
            rx_mem[rx_wr[5:0]] <= inj_byte;
            rx_wr <= rx_wr + 1;
        end
        if (wb_ack_i) begin
            if (log_n < 4096) begin
                log_adr[log_n]  = wb_adr_o;
                log_we[log_n]   = wb_we_o;
                log_byte[log_n] = wb_we_o ? wr_byte : slv_byte;
                log_dat[log_n]  = wb_dat_o;
                log_sel[log_n]  = wb_sel_o;
                log_done[log_n] = cfg_done_o;
            end
            log_n = log_n + 1;
            if (wb_we_o) begin
                if (wb_adr_o == 5'd3)
                    mdl_lcr <= wr_byte;
                else if (wb_adr_o == 5'd0 && !mdl_lcr[7]) begin
                    thr_cnt = thr_cnt + 1;
                    consec  = consec + 1;
                    if (consec > max_consec)
                        max_consec = consec;
                    if (loopback) begin
                        rx_mem[rx_wr[5:0]] <= wr_byte;
                        rx_wr <= rx_wr + 1;
                    end
                end
            end else begin
                if (wb_adr_o == 5'd5)
                    consec = 0;
                else if (wb_adr_o == 5'd0) begin
                    rb_reads = rb_reads + 1;
                    if (rx_rd != rx_wr)
                        rx_rd <= rx_rd + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rx_valid_o && rx_ready_i) begin
            rx_got[rx_n[5:0]] = rx_data_o;
            rx_n = rx_n + 1;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic inject(input logic [7:0] b);
        inj_byte = b;
        inj_go   = 1'b1;
        step(1);
        inj_go   = 1'b0;
    endtask

    task automatic drive_tx(input int n, input int budget);
        int   idx = 0;
        int   cyc = 0;
        logic hs;
        tx_data_i  = tx_src[0];
        tx_valid_i = 1'b1;
        while (idx < n && cyc < budget) begin
            @(negedge clk);
            hs = tx_valid_i && tx_ready_o;
            @(posedge clk);
            #1;
            if (hs)
                idx++;
            tx_valid_i = (idx < n);
            tx_data_i  = tx_src[idx[4:0]];
            cyc++;
        end
        tx_valid_i = 1'b0;
        checks++;
        if (idx != n) begin
            errors++;
            $display("[TB] FAIL tx_drain: accepted %0d bytes, required %0d", idx, n);
        end
    endtask

    task automatic wait_rx(input int n, input int budget);
        int c = 0;
        while (rx_n < n && c < budget) begin
            @(negedge clk);
            c++;
        end
        checks++;
        if (rx_n < n) begin
            errors++;
            $display("[TB] FAIL rx_count: received %0d bytes, required %0d", rx_n, n);
        end
        step(1);
    endtask

    task automatic test_reset();
        #2 wb_rst_i = 1'b1;
        step(3);
        checks++;
        if ({wb_cyc_o, wb_stb_o, wb_we_o} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: cyc/stb/we=%b, required 000", {wb_cyc_o, wb_stb_o, wb_we_o});
        end
        checks++;
        if ({wb_adr_o, wb_dat_o, wb_sel_o} !== 41'h0) begin
            errors++;
            $display("[TB] FAIL reset_bus: adr=%h dat=%h sel=%b, required all 0", wb_adr_o, wb_dat_o, wb_sel_o);
        end
        checks++;
        if ({tx_ready_o, rx_valid_o, cfg_done_o, err_o, rx_data_o} !== 14'h0) begin
            errors++;
            $display("[TB] FAIL reset_stream: tx_ready=%b rx_valid=%b cfg_done=%b err=%b rx_data=%h, required 0",
                     tx_ready_o, rx_valid_o, cfg_done_o, err_o, rx_data_o);
        end
    endtask

    task automatic test_config();
        logic [4:0]  exp_adr [5] = '{5'd3, 5'd0, 5'd1, 5'd3, 5'd1};
        logic [31:0] exp_dat [5] = '{32'h9B000000, 32'h00000002, 32'h00000000, 32'h1B000000, 32'h00000000};
        logic [3:0]  exp_sel [5] = '{4'b1000, 4'b0001, 4'b0010, 4'b1000, 4'b0010};
        div_i    = 16'd2;
        wb_rst_i = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k == 9) begin
                checks++;
                if (cfg_done_o !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL cfg_done_early: clock 9 cfg_done=%b, required 0", cfg_done_o);
                end
            end else if (k == 10) begin
                checks++;
                if (cfg_done_o !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL cfg_done_rise: clock 10 cfg_done=%b, required 1", cfg_done_o);
                end
            end
        end
        checks++;
        if (log_n != 5) begin
            errors++;
            $display("[TB] FAIL cfg_count: %0d accesses, required 5", log_n);
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (log_we[i] !== 1'b1 || log_adr[i] !== exp_adr[i] || log_dat[i] !== exp_dat[i] || log_sel[i] !== exp_sel[i]) begin
                errors++;
                $display("[TB] FAIL cfg_write%0d: we=%b adr=%0d dat=%h sel=%b, required we=1 adr=%0d dat=%h sel=%b",
                         i, log_we[i], log_adr[i], log_dat[i], log_sel[i], exp_adr[i], exp_dat[i], exp_sel[i]);
            end
        end
        step(1);
    endtask

    task automatic test_loopback();
        loopback   = 1'b1;
        rx_ready_i = 1'b1;
        rx_n       = 0;
        tx_src[0]  = 8'h81;
        tx_src[1]  = 8'h42;
        drive_tx(2, 200);
        wait_rx(2, 200);
        checks++;
        if (rx_got[0] !== 8'h81 || rx_got[1] !== 8'h42) begin
            errors++;
            $display("[TB] FAIL loop_data: got %h %h, required 81 42", rx_got[0], rx_got[1]);
        end
        checks++;
        if (err_o !== 3'b000) begin
            errors++;
            $display("[TB] FAIL loop_err: err=%b, required 000", err_o);
        end
    endtask

    task automatic test_back_to_back();
        rx_n       = 0;
        consec     = 0;
        max_consec = 0;
        for (int i = 0; i < 20; i++)
            tx_src[i] = 8'(8'h10 + 3 * i);
        drive_tx(20, 1000);
        wait_rx(20, 400);
        checks++;
        if (max_consec != 4) begin
            errors++;
            $display("[TB] FAIL burst_len: longest THR run %0d, required 4", max_consec);
        end
        for (int i = 0; i < 20; i++) begin
            checks++;
            if (rx_got[i] !== 8'(8'h10 + 3 * i)) begin
                errors++;
                $display("[TB] FAIL burst_byte%0d: got %h, required %h", i, rx_got[i], 8'(8'h10 + 3 * i));
            end
        end
    endtask

    task automatic test_backpressure();
        logic seen = 1'b0;
        logic dropped = 1'b0;
        loopback   = 1'b0;
        rx_ready_i = 1'b0;
        rx_n       = 0;
        rb_reads   = 0;
        for (int i = 1; i <= 6; i++)
            inject(8'(8'hC0 + i));
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (rx_valid_o)
                seen = 1'b1;
            else if (seen)
                dropped = 1'b1;
        end
        step(1);
        checks++;
        if (rb_reads != 4) begin
            errors++;
            $display("[TB] FAIL bp_reads: %0d RB reads while blocked, required 4", rb_reads);
        end
        checks++;
        if (rx_valid_o !== 1'b1 || dropped || rx_data_o !== 8'hC1) begin
            errors++;
            $display("[TB] FAIL bp_hold: valid=%b dropped=%b data=%h, required 1 0 c1", rx_valid_o, dropped, rx_data_o);
        end
        rx_ready_i = 1'b1;
        wait_rx(6, 200);
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (rx_got[i] !== 8'(8'hC1 + i)) begin
                errors++;
                $display("[TB] FAIL bp_byte%0d: got %h, required %h", i, rx_got[i], 8'(8'hC1 + i));
            end
        end
    endtask

    task automatic test_reconfig();
        logic [4:0] exp_adr [5] = '{5'd3, 5'd0, 5'd1, 5'd3, 5'd1};
        logic [7:0] exp_byte [5] = '{8'h9B, 8'h05, 8'h00, 8'h1B, 8'h00};
        int log_start;
        int thr_base;
        int d = -1;
        int thr_between = 0;
        loopback  = 1'b1;
        rx_n      = 0;
        div_i     = 16'd5;
        for (int i = 0; i < 8; i++)
            tx_src[i] = 8'(8'hA0 + i);
        log_start = log_n;
        thr_base  = thr_cnt;
        fork
            drive_tx(8, 1000);
            begin
                int c = 0;
                while (thr_cnt == thr_base && c < 100) begin
                    @(negedge clk);
                    c++;
                end
                @(posedge clk);
                #1 cfg_req_i = 1'b1;
                step(1);
                cfg_req_i = 1'b0;
            end
        join
        wait_rx(8, 400);
        for (int i = log_start; i < log_n && i < 4090; i++)
            if (d < 0 && log_we[i] && log_adr[i] == 5'd3 && log_byte[i] == 8'h9B)
                d = i;
        checks++;
        if (d < log_start + 1) begin
            errors++;
            $display("[TB] FAIL recfg_found: DLAB write index %0d, required > %0d", d, log_start);
        end else begin
            for (int i = log_start; i < d; i++)
                if (log_we[i] && log_adr[i] == 5'd0)
                    thr_between++;
            checks++;
            if (thr_between != 4) begin
                errors++;
                $display("[TB] FAIL recfg_burst: %0d THR writes before reconfig, required 4", thr_between);
            end
            checks++;
            if (log_we[d-1] !== 1'b0 || log_adr[d-1] !== 5'd5) begin
                errors++;
                $display("[TB] FAIL recfg_poll: prior access we=%b adr=%0d, required LSR read", log_we[d-1], log_adr[d-1]);
            end
            for (int j = 0; j < 5; j++) begin
                checks++;
                if (log_we[d+j] !== 1'b1 || log_adr[d+j] !== exp_adr[j] || log_byte[d+j] !== exp_byte[j]) begin
                    errors++;
                    $display("[TB] FAIL recfg_write%0d: we=%b adr=%0d byte=%h, required 1 %0d %h",
                             j, log_we[d+j], log_adr[d+j], log_byte[d+j], exp_adr[j], exp_byte[j]);
                end
            end
            checks++;
            if (log_done[d] !== 1'b0 || log_done[d+4] !== 1'b0 || log_done[d+5] !== 1'b1) begin
                errors++;
                $display("[TB] FAIL recfg_done: cfg_done at DLAB/IER/after=%b%b%b, required 001",
                         log_done[d], log_done[d+4], log_done[d+5]);
            end
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (rx_got[i] !== 8'(8'hA0 + i)) begin
                errors++;
                $display("[TB] FAIL recfg_byte%0d: got %h, required %h", i, rx_got[i], 8'(8'hA0 + i));
            end
        end
    endtask

    task automatic test_errors_reset();
        int c = 0;
        loopback   = 1'b0;
        rx_ready_i = 1'b0;
        f_pe       = 1'b1;
        step(8);
        checks++;
        if (err_o !== 3'b010) begin
            errors++;
            $display("[TB] FAIL err_set: err=%b, required 010", err_o);
        end
        f_pe = 1'b0;
        step(8);
        checks++;
        if (err_o !== 3'b010) begin
            errors++;
            $display("[TB] FAIL err_sticky: err=%b, required 010", err_o);
        end
        err_clr_i = 1'b1;
        step(1);
        err_clr_i = 1'b0;
        checks++;
        if (err_o !== 3'b000) begin
            errors++;
            $display("[TB] FAIL err_clear: err=%b, required 000", err_o);
        end
        inject(8'h5A);
        step(10);
        checks++;
        if (rx_valid_o !== 1'b1 || rx_data_o !== 8'h5A) begin
            errors++;
            $display("[TB] FAIL rst_prefill: valid=%b data=%h, required 1 5a", rx_valid_o, rx_data_o);
        end
        stall = 1'b1;
        while (!wb_cyc_o && c < 10) begin
            @(negedge clk);
            c++;
        end
        checks++;
        if (wb_cyc_o !== 1'b1 || wb_we_o !== 1'b0 || wb_adr_o !== 5'd5) begin
            errors++;
            $display("[TB] FAIL rst_stalled: cyc=%b we=%b adr=%0d, required pending LSR read", wb_cyc_o, wb_we_o, wb_adr_o);
        end
        @(posedge clk);
        #1 wb_rst_i = 1'b1;
        #1;
        checks++;
        if (wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0 || rx_valid_o !== 1'b0 || cfg_done_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rst_abort: cyc=%b stb=%b rx_valid=%b cfg_done=%b, required 0",
                     wb_cyc_o, wb_stb_o, rx_valid_o, cfg_done_o);
        end
        log_n = 0;
        stall = 1'b0;
        step(2);
        wb_rst_i = 1'b0;
        step(10);
        checks++;
        if (cfg_done_o !== 1'b1 || log_n != 5 || log_byte[0] !== 8'h9B || log_adr[0] !== 5'd3 || log_byte[1] !== 8'h05) begin
            errors++;
            $display("[TB] FAIL rst_restart: cfg_done=%b accesses=%0d first=%0d/%h dl1=%h, required 1 5 3/9b 05",
                     cfg_done_o, log_n, log_adr[0], log_byte[0], log_byte[1]);
        end
    endtask

    initial begin
        test_reset();
        test_config();
        test_loopback();
        test_back_to_back();
        test_backpressure();
        test_reconfig();
        test_errors_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
